// File: rtl/addatone_ctrl_pkg.sv
// addatone_ctrl_pkg: channel indices, state encoding and defaults shared by the control register bank
package addatone_ctrl_pkg;
  localparam int NUM_CHANNELS = 7;
  typedef logic [2:0] ch_idx_t;
  localparam ch_idx_t CH_FREQ    = 3'd0;
  localparam ch_idx_t CH_HSCALE0 = 3'd1;
  localparam ch_idx_t CH_SINIT0  = 3'd2;
  localparam ch_idx_t CH_HSCALE1 = 3'd3;
  localparam ch_idx_t CH_SINIT1  = 3'd4;
  localparam ch_idx_t CH_FSCALE  = 3'd5;
  localparam ch_idx_t CH_HCOUNT  = 3'd6;
  localparam int DEF_MAX_HARMONICS = 100;
  typedef enum logic {IDLE, FILTER} state_t;
endpackage

// File: rtl/control_slew_alu.sv
// control_slew_alu: one combinational slew-filter step for a single channel (acc, target -> acc_next)
// Ports: acc_i current accumulator, target_i target word, acc_o next accumulator.
// Macro SMOOTHING_EN: defined = one-pole slew filter, undefined = bypass (acc_o = target<<SMOOTH_SHIFT).
module control_slew_alu #(
  parameter int DATA_WIDTH   = 16,
  parameter int SMOOTH_SHIFT = 3
) (
  input  logic [DATA_WIDTH+SMOOTH_SHIFT-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0]              target_i,
  output logic [DATA_WIDTH+SMOOTH_SHIFT-1:0] acc_o
);
  localparam int AW = DATA_WIDTH + SMOOTH_SHIFT;
`ifdef SMOOTHING_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif
  localparam logic signed [AW:0] LIM = (AW+1)'(1 << SMOOTH_SHIFT);
  logic [AW-1:0]      t;
  logic signed [AW:0] diff;
  logic               snap;
  assign t    = {target_i, {SMOOTH_SHIFT{1'b0}}};
  assign diff = $signed({1'b0, t}) - $signed({1'b0, acc_i});
  // Residual errors below one output LSB snap straight to target so the filter always settles.
  assign snap  = !SMOOTH || (diff < LIM && diff > -LIM);
  // Step magnitude never exceeds |diff|, so the modular add cannot wrap past the target.
  assign acc_o = snap ? t : AW'({1'b0, acc_i} + $unsigned(diff >>> SMOOTH_SHIFT));
endmodule

// File: rtl/control_register_bank.sv
// control_register_bank: synchronises ADC control words, slew-filters them and commits on frame boundaries
// Ports: Main_Clock/Reset (sync, active-high); i_Data_Received async capture strobe; i_Data0..6 ADC words;
// i_Frame_Sync sample-boundary pulse; o_* committed control values; o_Update commit pulse; o_Busy filter pass.
// Macro SMOOTHING_EN selects the slew filter in control_slew_alu; undefined bypasses it.
module control_register_bank
  import addatone_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int DIV_BIT       = 11,
  parameter int SMOOTH_SHIFT  = 3,
  parameter int MAX_HARMONICS = DEF_MAX_HARMONICS
) (
  input  logic                  Main_Clock,
  input  logic                  Reset,
  input  logic                  i_Data_Received,
  input  logic [DATA_WIDTH-1:0] i_Data0,
  input  logic [DATA_WIDTH-1:0] i_Data1,
  input  logic [DATA_WIDTH-1:0] i_Data2,
  input  logic [DATA_WIDTH-1:0] i_Data3,
  input  logic [DATA_WIDTH-1:0] i_Data4,
  input  logic [DATA_WIDTH-1:0] i_Data5,
  input  logic [DATA_WIDTH-1:0] i_Data6,
  input  logic                  i_Frame_Sync,
  output logic [DATA_WIDTH-1:0] o_Frequency,
  output logic [DIV_BIT-1:0]    o_Harmonic_Scale0,
  output logic [DIV_BIT-1:0]    o_Scale_Initial0,
  output logic [DIV_BIT-1:0]    o_Harmonic_Scale1,
  output logic [DIV_BIT-1:0]    o_Scale_Initial1,
  output logic [DATA_WIDTH-1:0] o_Freq_Scale,
  output logic [7:0]            o_Harmonic_Count,
  output logic                  o_Update,
  output logic                  o_Busy
);
  localparam int AW = DATA_WIDTH + SMOOTH_SHIFT;
  localparam logic [DATA_WIDTH-1:0] MAXH = DATA_WIDTH'(MAX_HARMONICS);
  logic [2:0]            sync_q;
  logic                  capture;
  logic                  start;
  logic [DATA_WIDTH-1:0] words  [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] pend_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] targ_q [NUM_CHANNELS];
  logic [AW-1:0]         acc_q  [NUM_CHANNELS-1];
  logic [AW-1:0]         acc_d;
  logic [7:0]            hc_q;
  logic [7:0]            hc_d;
  state_t                state_q;
  ch_idx_t               idx_q;
  ch_idx_t               ch;
  logic                  defer_q;
  assign words   = '{i_Data0, i_Data1, i_Data2, i_Data3, i_Data4, i_Data5, i_Data6};
  // sync_q[1:0] is the 2-FF synchroniser, sync_q[2] the delayed copy for edge detection.
  assign capture = sync_q[1] & ~sync_q[2];
  assign start   = state_q == IDLE && (i_Frame_Sync || defer_q);
  // Channel 6 has no accumulator; park the ALU on channel 0 while it is processed.
  assign ch      = idx_q == CH_HCOUNT ? CH_FREQ : idx_q;
  assign hc_d    = targ_q[CH_HCOUNT] > MAXH ? MAXH[7:0] : targ_q[CH_HCOUNT][7:0];
  control_slew_alu #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SMOOTH_SHIFT(SMOOTH_SHIFT)
  ) u_alu (
    .acc_i   (acc_q[ch]),
    .target_i(targ_q[ch]),
    .acc_o   (acc_d)
  );
  always_ff @(posedge Main_Clock) begin
    if (Reset) begin
      sync_q            <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        pend_q[i] <= '0;
        targ_q[i] <= '0;
      end
      for (int i = 0; i < NUM_CHANNELS - 1; i++) acc_q[i] <= '0;
      hc_q              <= '0;
      o_Frequency       <= '0;
      o_Harmonic_Scale0 <= '0;
      o_Scale_Initial0  <= '0;
      o_Harmonic_Scale1 <= '0;
      o_Scale_Initial1  <= '0;
      o_Freq_Scale      <= '0;
      o_Harmonic_Count  <= '0;
      o_Update          <= 1'b0;
      o_Busy            <= 1'b0;
      state_q           <= IDLE;
      idx_q             <= '0;
      defer_q           <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], i_Data_Received};
      o_Update <= start;
      if (capture) for (int i = 0; i < NUM_CHANNELS; i++) pend_q[i] <= words[i];
      if (start) begin
        o_Frequency       <= acc_q[CH_FREQ][AW-1:SMOOTH_SHIFT];
        o_Harmonic_Scale0 <= acc_q[CH_HSCALE0][SMOOTH_SHIFT+DIV_BIT-1:SMOOTH_SHIFT];
        o_Scale_Initial0  <= acc_q[CH_SINIT0][SMOOTH_SHIFT+DIV_BIT-1:SMOOTH_SHIFT];
        o_Harmonic_Scale1 <= acc_q[CH_HSCALE1][SMOOTH_SHIFT+DIV_BIT-1:SMOOTH_SHIFT];
        o_Scale_Initial1  <= acc_q[CH_SINIT1][SMOOTH_SHIFT+DIV_BIT-1:SMOOTH_SHIFT];
        o_Freq_Scale      <= acc_q[CH_FSCALE][AW-1:SMOOTH_SHIFT];
        o_Harmonic_Count  <= hc_q;
        // A capture landing in the commit cycle bypasses pending so it joins this pass.
        for (int i = 0; i < NUM_CHANNELS; i++) targ_q[i] <= capture ? words[i] : pend_q[i];
        idx_q             <= '0;
        state_q           <= FILTER;
        o_Busy            <= 1'b1;
        defer_q           <= 1'b0;
      end else if (state_q == FILTER) begin
        if (i_Frame_Sync) defer_q <= 1'b1;
        if (idx_q == CH_HCOUNT) begin
          hc_q    <= hc_d;
          state_q <= IDLE;
          o_Busy  <= 1'b0;
        end else begin
          acc_q[ch] <= acc_d;
          idx_q     <= idx_q + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_control_register_bank.sv
// tb_control_register_bank: table-driven vectors plus a commit scoreboard for control_register_bank
module tb_control_register_bank;
  typedef struct packed {
    logic [15:0] f;
    logic [10:0] hs0;
    logic [10:0] si0;
    logic [10:0] hs1;
    logic [10:0] si1;
    logic [15:0] fs;
    logic [7:0]  hc;
  } out_t;
  typedef struct {
    logic [15:0] w [7];
    logic [7:0]  hc;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drec = 1'b0;
  logic        fsync = 1'b0;
  logic [15:0] d [7];
  logic [15:0] o_freq, o_fs;
  logic [10:0] o_hs0, o_si0, o_hs1, o_si1;
  logic [7:0]  o_hc;
  logic        o_upd, o_busy;
  out_t        act;
  out_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  int          m_acc [6];
  int          m_pend [7];
  int          m_targ [7];
  int          m_hc;
  vec_t        tbl [6];
  always #5 clk = ~clk;
  control_register_bank dut (
    .Main_Clock       (clk),
    .Reset            (rst),
    .i_Data_Received  (drec),
    .i_Data0          (d[0]),
    .i_Data1          (d[1]),
    .i_Data2          (d[2]),
    .i_Data3          (d[3]),
    .i_Data4          (d[4]),
    .i_Data5          (d[5]),
    .i_Data6          (d[6]),
    .i_Frame_Sync     (fsync),
    .o_Frequency      (o_freq),
    .o_Harmonic_Scale0(o_hs0),
    .o_Scale_Initial0 (o_si0),
    .o_Harmonic_Scale1(o_hs1),
    .o_Scale_Initial1 (o_si1),
    .o_Freq_Scale     (o_fs),
    .o_Harmonic_Count (o_hc),
    .o_Update         (o_upd),
    .o_Busy           (o_busy)
  );
  assign act = {o_freq, o_hs0, o_si0, o_hs1, o_si1, o_fs, o_hc};
  function automatic int slew(input int acc, input int tgt);
    int t;
    int e;
    t = tgt * 8;
    e = t - acc;
`ifdef SMOOTHING_EN
    if (e < 8 && e > -8) return t;
    return acc + (e >>> 3);
`else
    return t;
`endif
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 6; i++) m_acc[i] = 0;
    for (int i = 0; i < 7; i++) begin
      m_pend[i] = 0;
      m_targ[i] = 0;
    end
    m_hc = 0;
    sb.delete();
  endtask
  task automatic m_commit();
    out_t e;
    e.f   = 16'(m_acc[0] >> 3);
    e.hs0 = 11'(m_acc[1] >> 3);
    e.si0 = 11'(m_acc[2] >> 3);
    e.hs1 = 11'(m_acc[3] >> 3);
    e.si1 = 11'(m_acc[4] >> 3);
    e.fs  = 16'(m_acc[5] >> 3);
    e.hc  = 8'(m_hc);
    sb.push_back(e);
    for (int i = 0; i < 7; i++) m_targ[i] = m_pend[i];
    for (int i = 0; i < 6; i++) m_acc[i] = slew(m_acc[i], m_targ[i]);
    m_hc = m_targ[6] > 100 ? 100 : m_targ[6];
  endtask
  task automatic chk(input string name, input logic [83:0] a, input logic [83:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  always @(negedge clk) begin : monitor
    out_t e;
    if (o_upd) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL commit: unexpected o_Update, outputs %h", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL commit: got %h expected %h", act, e);
        end
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    m_reset();
  endtask
  task automatic capture(input logic [15:0] w [7]);
    d    = w;
    drec = 1'b1;
    tick(5);
    drec = 1'b0;
    tick(3);
    for (int i = 0; i < 7; i++) m_pend[i] = int'(w[i]);
  endtask
  task automatic sync_pass(output out_t got);
    int busy;
    m_commit();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    got   = act;
    busy  = 0;
    for (int i = 0; i < 10; i++) begin
      busy += int'(o_busy);
      tick();
    end
    chk("busy_cycles", 84'(busy), 84'd7);
  endtask
  initial begin
    out_t        g;
    logic [15:0] w [7];
    logic [15:0] exp_f [3];
    for (int i = 0; i < 7; i++) d[i] = '0;
    tbl[0].w = '{16'd800, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd250};            tbl[0].hc = 8'd100;
    tbl[1].w = '{16'd1234, 16'h0FFF, 16'h0123, 16'h07FF, 16'h0400, 16'hFFFF, 16'd42}; tbl[1].hc = 8'd42;
    tbl[2].w = '{16'hFFFF, 16'h0001, 16'h0800, 16'h0009, 16'h0555, 16'h1234, 16'h0164}; tbl[2].hc = 8'd100;
    tbl[3].w = '{16'd5, 16'd3, 16'd7, 16'd100, 16'd2000, 16'd9, 16'd100};          tbl[3].hc = 8'd100;
    tbl[4].w = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd101};               tbl[4].hc = 8'd100;
    tbl[5].w = '{16'd7, 16'h07FF, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0};              tbl[5].hc = 8'd0;
    do_reset();
    chk("reset_outputs", 84'(act), 84'd0);
    chk("reset_update_busy", {82'd0, o_upd, o_busy}, 84'd0);
    w = '{16'h1111, 16'h0222, 16'h0333, 16'h0444, 16'h0555, 16'h6666, 16'd77};
    capture(w);
    do_reset();
    chk("reset_after_capture", 84'(act), 84'd0);
    tick(12);
    chk("no_commit_without_sync", {act, o_upd, o_busy}, 84'd0);
    sync_pass(g);
    sync_pass(g);
    chk("pending_cleared_by_reset", 84'(g), 84'd0);
    do_reset();
    w = '{16'd800, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    capture(w);
`ifdef SMOOTHING_EN
    exp_f = '{16'd0, 16'd100, 16'd187};
`else
    exp_f = '{16'd0, 16'd800, 16'd800};
`endif
    for (int i = 0; i < 3; i++) begin
      sync_pass(g);
      chk($sformatf("step_freq_%0d", i), 84'(g.f), 84'(exp_f[i]));
    end
    do_reset();
    w = '{16'd0, 16'h0FFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    capture(w);
    sync_pass(g);
    sync_pass(g);
`ifdef SMOOTHING_EN
    chk("scale0_after_two_syncs", 84'(g.hs0), 84'h1FF);
`else
    chk("scale0_after_two_syncs", 84'(g.hs0), 84'h7FF);
`endif
    for (int v = 0; v < 6; v++) begin
      capture(tbl[v].w);
      sync_pass(g);
      sync_pass(g);
      chk($sformatf("hcount_vec%0d", v), 84'(g.hc), 84'(tbl[v].hc));
    end
    w = '{16'd300, 16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd77};
    d    = w;
    drec = 1'b1;
    tick(2);
    for (int i = 0; i < 7; i++) m_pend[i] = int'(w[i]);
    m_commit();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick(9);
    drec = 1'b0;
    tick(3);
    sync_pass(g);
    chk("collision_capture_used", 84'(g.hc), 84'd77);
    m_commit();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    w = '{16'd900, 16'd11, 16'd22, 16'd33, 16'd44, 16'd55, 16'd33};
    d    = w;
    drec = 1'b1;
    tick(5);
    drec = 1'b0;
    for (int i = 0; i < 7; i++) m_pend[i] = int'(w[i]);
    tick(5);
    sync_pass(g);
    chk("filter_capture_deferred", 84'(g.hc), 84'd77);
    sync_pass(g);
    chk("filter_capture_next_frame", 84'(g.hc), 84'd33);
    m_commit();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick(2);
    m_commit();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick(4);
    chk("deferred_not_early", 84'(o_upd), 84'd0);
    tick();
    chk("deferred_update_t9", 84'(o_upd), 84'd1);
    tick(10);
    m_commit();
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    tick(2);
    fsync = 1'b1;
    tick();
    fsync = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    m_reset();
    chk("midpass_reset", {act, o_upd, o_busy}, 84'd0);
    tick(15);
    chk("midpass_reset_no_deferred", {act, o_upd, o_busy}, 84'd0);
    chk("scoreboard_drained", 84'(sb.size()), 84'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
